// File: rtl/ram_reader.sv
// ram_reader: sequential read-back engine for the 256x16 result RAM.
// On start it fetches `count` consecutive words from `base_addr` (address
// wraps mod 2**ADDR_W), streams each one out over a valid/ready port, and
// pulses `done` once the burst is finished. `reset` is asynchronous and
// active-low; the same net drives the RAM's RSTB at the top level.
module ram_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [8:0]        count,
  output logic              mem_CEB,
  output logic              mem_WEB,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  // Largest burst the RAM can supply without revisiting an address.
  localparam logic [8:0] MAX_WORDS = 9'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    SEND,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [8:0]        remaining;
  logic [8:0]        count_sat;
  logic              accept;
  logic              handshake;

  // Bursts longer than the RAM clamp to one full pass.
  assign count_sat = (count > MAX_WORDS) ? MAX_WORDS : count;
  assign accept    = (state == IDLE) && start;
  assign handshake = (state == SEND) && out_ready;

  // The block is read-only, so the write strobe is permanently inactive.
  assign mem_WEB  = 1'b1;
  assign mem_addr = addr_q;

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours, matching the hardware.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and the state-derived control outputs.
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    mem_CEB    = 1'b1;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = (count_sat == 9'd0) ? DONE : FETCH;
      end
      FETCH: begin
        mem_CEB    = 1'b0;
        state_next = CAPTURE;
      end
      CAPTURE: begin
        state_next = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = (remaining == 9'd1);
        if (out_ready) state_next = (remaining == 9'd1) ? DONE : FETCH;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: address/count bookkeeping and the registered output word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      remaining <= '0;
      out_data  <= '0;
    end else begin
      if (accept) begin
        addr_q    <= base_addr;
        remaining <= count_sat;
      end
      // RAM data is valid one cycle after the FETCH edge, i.e. during CAPTURE.
      if (state == CAPTURE) out_data <= mem_q;
      if (handshake) begin
        addr_q    <= addr_q + ADDR_W'(1);
        remaining <= remaining - 9'd1;
      end
    end
  end

endmodule
